// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the load/store unit.
//   lsu_size_e  : access size encoding carried on req_size
//   lsu_state_e : control FSM states (also exported for observation)
//   *_W         : lane widths used for little-endian lane extraction
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam int XLEN      = 32;
    localparam int BYTE_W    = 8;
    localparam int HALF_W    = 16;
    localparam int NUM_LANES = XLEN / BYTE_W;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// -----------------------------------------------------------------------------
// lsu_if
// Bundles the request/response channel and the data-memory port of the
// load/store unit.
//   slave  : the load/store unit side
//   master : the execute stage + memory side (used by the testbench)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload stable until that edge;
// the consumer may raise or drop ready freely. For requests, ready is high
// only while the unit is idle; for responses, resp_valid stays high with
// rdata/err frozen until resp_ready is seen.
//
// Memory port: mem_rd is the registered read of the word at mem_addr,
// valid one cycle after mem_addr is presented with mem_wr_en low.
// -----------------------------------------------------------------------------
interface lsu_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    // request channel
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [1:0]               req_size;
    logic                     req_unsigned;
    logic [31:0]              req_addr;
    logic [31:0]              req_wdata;
    // response channel
    logic                     resp_valid;
    logic                     resp_ready;
    logic [31:0]              resp_rdata;
    logic                     resp_err;
    // data memory port
    logic                     mem_wr_en;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wd;
    logic [DATA_WIDTH-1:0]    mem_rd;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_wr_en, mem_addr, mem_wd
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_wr_en, mem_addr, mem_wd
    );

endinterface

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational lane handling for a 32-bit little-endian word.
//   i_size     : access size (byte/half/word)
//   i_unsigned : 1 = zero-extend loads, 0 = sign-extend from lane MSB
//   i_addr_lo  : byte offset within the word (already normalised by caller)
//   i_rd       : word read from memory
//   i_wdata    : right-justified store data
//   o_load     : extracted and extended load result
//   o_merged   : i_rd with only the addressed lane replaced by store data
// -----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
(
    input  lsu_size_e   i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rd,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [BYTE_W-1:0] w_byte;
    logic [HALF_W-1:0] w_half;
    logic              w_byte_sign;
    logic              w_half_sign;

    always_comb begin
        w_byte = i_rd[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rd[15:8];
            2'd2:    w_byte = i_rd[23:16];
            2'd3:    w_byte = i_rd[31:24];
            default: w_byte = i_rd[7:0];
        endcase
        w_half      = i_addr_lo[1] ? i_rd[31:16] : i_rd[15:0];
        w_byte_sign = ~i_unsigned & w_byte[BYTE_W-1];
        w_half_sign = ~i_unsigned & w_half[HALF_W-1];

        // Word accesses pass straight through in both directions.
        o_load   = i_rd;
        o_merged = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_load   = {{(XLEN-BYTE_W){w_byte_sign}}, w_byte};
                o_merged = i_rd;
                case (i_addr_lo)
                    2'd1:    o_merged[15:8]  = i_wdata[7:0];
                    2'd2:    o_merged[23:16] = i_wdata[7:0];
                    2'd3:    o_merged[31:24] = i_wdata[7:0];
                    default: o_merged[7:0]   = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                o_load   = {{(XLEN-HALF_W){w_half_sign}}, w_half};
                o_merged = i_rd;
                if (i_addr_lo[1]) begin
                    o_merged[31:16] = i_wdata[15:0];
                end else begin
                    o_merged[15:0]  = i_wdata[15:0];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Byte/half/word loads and stores on byte addresses against a word-addressed
// memory with a registered read port. Sub-word stores are read-modify-write.
// One transaction in flight at a time.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : lsu_if.slave - request/response channel and memory port
//   o_state    : current FSM state, for observation
//
// Build option: define LSU_MISALIGN_TRAP_EN to report misaligned half/word
// accesses and the reserved size as errors (no memory access). Without it,
// resp_err is always 0, offending low address bits are cleared and the
// reserved size behaves as a word access.
//
// Latency from the accept edge (cycle 0) to first resp_valid:
//   error 1, word store 2, load 3, sub-word store 4.
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32   // only 32 is supported
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_if.slave       bus,
    output lsu_state_e o_state
);

    lsu_state_e             r_state;
    lsu_state_e             w_next_state;

    logic                   r_we;
    lsu_size_e              r_size;
    logic                   r_unsigned;
    logic [1:0]             r_addr_lo;
    logic [31:0]            r_wdata;
    logic [31:0]            r_rdata;
    logic                   r_err;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [31:0]            r_mem_wd;

    logic                   w_accept;
    lsu_size_e              w_in_size;
    lsu_size_e              w_eff_size;
    logic [1:0]             w_eff_lo;
    logic                   w_err;
    logic                   w_word_store;
    logic [63:0]            w_idx_wide;
    logic [31:0]            w_load;
    logic [31:0]            w_merged;

    assign w_accept   = bus.req_valid && (r_state == ST_IDLE);
    assign w_in_size  = lsu_size_e'(bus.req_size);
    // Word index zero-extended wide enough to be truncated to any ADDRESS_WIDTH.
    assign w_idx_wide = {34'd0, bus.req_addr[31:2]};

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        w_eff_size = w_in_size;
        w_eff_lo   = bus.req_addr[1:0];
        w_err      = (w_in_size == SZ_RSVD)
                  || ((w_in_size == SZ_HALF) && bus.req_addr[0])
                  || ((w_in_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
    end
`else
    always_comb begin
        w_err      = 1'b0;
        w_eff_size = (w_in_size == SZ_RSVD) ? SZ_WORD : w_in_size;
        w_eff_lo   = bus.req_addr[1:0];
        if (w_eff_size == SZ_HALF) begin
            w_eff_lo = {bus.req_addr[1], 1'b0};
        end else if (w_eff_size == SZ_WORD) begin
            w_eff_lo = 2'b00;
        end
    end
`endif

    assign w_word_store = bus.req_we && (w_eff_size == SZ_WORD);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_next_state = ST_RESP;
                    end else if (w_word_store) begin
                        w_next_state = ST_WR;
                    end else begin
                        w_next_state = ST_RD;
                    end
                end
            end
            ST_RD:   w_next_state = ST_CAP;
            ST_CAP:  w_next_state = r_we ? ST_WR : ST_RESP;
            ST_WR:   w_next_state = ST_RESP;
            ST_RESP: w_next_state = bus.resp_ready ? ST_IDLE : ST_RESP;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request latch, memory port registers and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_addr_lo  <= 2'b00;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_mem_addr <= '0;
            r_mem_wd   <= '0;
        end else begin
            if (w_accept) begin
                r_we       <= bus.req_we;
                r_size     <= w_eff_size;
                r_unsigned <= bus.req_unsigned;
                r_addr_lo  <= w_eff_lo;
                r_wdata    <= bus.req_wdata;
                r_rdata    <= '0;
                r_err      <= w_err;
                // An erroring request leaves the memory port untouched.
                if (!w_err) begin
                    r_mem_addr <= w_idx_wide[ADDRESS_WIDTH-1:0];
                    if (w_word_store) begin
                        r_mem_wd <= bus.req_wdata;
                    end
                end
            end
            if (r_state == ST_CAP) begin
                if (r_we) begin
                    r_mem_wd <= w_merged;
                end else begin
                    r_rdata  <= w_load;
                end
            end
        end
    end

    lsu_lane_align u_lane_align (
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_addr_lo  (r_addr_lo),
        .i_rd       (bus.mem_rd),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_merged   (w_merged)
    );

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.resp_valid = (r_state == ST_RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
    assign bus.mem_wr_en  = (r_state == ST_WR);
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wd     = r_mem_wd;
    assign o_state        = r_state;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the execute stage and the word-addressed data memory. Accepts byte, halfword and word loads/stores on byte addresses over a valid/ready request channel. Drives the memory's write-enable/address/write-data port and consumes its registered read port. Sub-word stores are read-modify-write; loads are lane-extracted and sign- or zero-extended before a valid/ready response.

## Interface
- ADDRESS_WIDTH, 32, width of memory word index `mem_addr`
- DATA_WIDTH, 32, memory word width; only 32 supported
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  misaligned/reserved-size error
- mem_wr_en  out  1  memory write strobe
- mem_addr  out  ADDRESS_WIDTH  word index = req_addr[31:2], zero-extended/truncated
- mem_wd  out  DATA_WIDTH  memory write word
- mem_rd  in  DATA_WIDTH  memory read word, valid the cycle after read address presented with mem_wr_en=0

## Operation
- States: IDLE, RD, CAP, WR, RESP.
- IDLE: accept on req_valid & req_ready; latch we, size, unsigned, addr, wdata.
  - error (see Configuration) -> RESP, resp_err=1, no memory access
  - word store -> WR
  - load or sub-word store -> RD
- RD: mem_addr = latched index, mem_wr_en=0 -> CAP.
- CAP: sample mem_rd.
  - load: extract lane, extend, register into resp_rdata -> RESP
  - store: merge into mem_wd -> WR
- WR: mem_wr_en=1 exactly this cycle; mem_addr/mem_wd from registers -> RESP.
- RESP: resp_valid=1; rdata/err held stable; on resp_ready -> IDLE.
- Lanes little-endian: byte lane = addr[1:0] (bits 8*lane+7:8*lane); half lane = addr[1] (bits 16*addr[1]+15:...).
- Merge: replace only addressed lane with req_wdata[7:0] / [15:0]; other bytes from mem_rd.
- Extension: sign from lane MSB when req_unsigned=0, else zero.
- mem_wr_en low in every state except WR; mem_addr/mem_wd hold last value outside RD/WR.
- No pipelining: one transaction outstanding; req_ready=0 from acceptance until RESP handshake completes.

## Timing
- Reset values: state IDLE, req_ready=1 after deassertion, resp_valid=0, resp_rdata=0, resp_err=0, mem_wr_en=0, mem_addr=0, mem_wd=0.
- Accept edge = cycle 0. resp_valid first high: error cycle 1; word store cycle 2; load cycle 3; sub-word store cycle 4.
- Write committed at end of WR; response never precedes write.
- resp_ready high on first RESP cycle: IDLE next cycle; next accept one cycle after response handshake.
- resp_ready held low: stay in RESP indefinitely, outputs stable.
- Reset mid-transaction: immediate return to IDLE, response dropped; write happens only if WR edge already passed.
- req_valid while busy: ignored, not latched.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1, word with addr[1:0]!=0, or req_size=11 -> error path, resp_err=1, resp_rdata=0, no memory read/write.
- Undefined: resp_err tied 0; offending low address bits cleared (half clears bit 0, word clears bits 1:0); size 11 treated as word.

## Structure
- Package lsu_pkg: size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD), state enum, byte-lane constants.
- Sub-module lsu_lane_align: combinational extract/extend for loads and merge for stores; FSM and registers stay in load_store_unit.

## Test plan
- Reset during load in CAP -> all outputs at reset values, req_ready=1 after release, no response.
- Word store 0xDEADBEEF @0x10 -> mem_wr_en one cycle, mem_addr=0x4, mem_wd=0xDEADBEEF, resp_valid at cycle 2, resp_err=0.
- Byte store 0xAA @0x13 over 0x11223344 -> read of index 0x4, then write 0xAA223344, resp at cycle 4.
- Loads on word 0x8001_AA00 @0x10: byte @0x11 signed -> 0xFFFFFFAA, unsigned -> 0x000000AA; half @0x12 signed -> 0xFFFF8001; resp at cycle 3.
- Half load @0x11: macro defined -> resp_err=1 at cycle 1, no memory access; undefined -> data of half @0x10.
- resp_ready low 5 cycles during load response -> resp_valid/resp_rdata stable, req_ready=0, concurrent req_valid not accepted.
